// File: rtl/raster_core.sv
// Triangle raster engine: takes one 10-beat setup packet, walks the
// y_count x x_len pixel box and streams {15'b0, covered, z[15:0]} per pixel.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   LOAD   | collecting setup beats; s_axis_tready high
//   RASTER | emitting pixel words; advances only on m_axis handshake
module raster_core #(
  parameter logic [31:0] ONE_Q     = 32'h4000_0000,
  parameter int          PKT_BEATS = 10
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready
);

  typedef enum logic {LOAD, RASTER} state_t;

  localparam logic [3:0] LAST_BEAT = 4'(PKT_BEATS - 1);

  state_t      state, state_next;
  logic [3:0]  beat_cnt;

  logic [15:0] x_len;
  logic [7:0]  y_count;
  logic [31:0] l0_base, l1_base, dl0x, dl1x, dl0y, dl1y;
  logic [15:0] z_base, dzx, dzy;

  logic [31:0] row_l0, row_l1, pix_l0, pix_l1;
  logic [15:0] row_z, pix_z;
  logic [15:0] x_cnt;
  logic [7:0]  y_cnt;

  logic               s_hs, m_hs, last_beat, pkt_done, box_empty;
  logic               x_last, y_last, covered;
  logic signed [32:0] l_sum;

  assign s_hs      = s_axis_tvalid & s_axis_tready;
  assign m_hs      = m_axis_tvalid & m_axis_tready;
  assign last_beat = (beat_cnt == LAST_BEAT);
  assign pkt_done  = s_hs & last_beat;
  // Header is stored on beat 0, so it is already valid when beat 9 lands.
  assign box_empty = (x_len == 16'd0) || (y_count == 8'd0);
  assign x_last    = (x_cnt == x_len - 16'd1);
  assign y_last    = (y_cnt == y_count - 8'd1);

  // Sign-extend both lambdas so the sum cannot overflow before the compare.
  assign l_sum   = $signed({pix_l0[31], pix_l0}) + $signed({pix_l1[31], pix_l1});
  assign covered = ~pix_l0[31] & ~pix_l1[31] & (l_sum <= $signed({1'b0, ONE_Q}));

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) state <= LOAD;
    else        state <= state_next;
  end

  // Next-state and output decode; outputs depend only on registered state.
  always_comb begin
    state_next    = state;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = 32'd0;
    case (state)
      LOAD: begin
        s_axis_tready = 1'b1;
        if (pkt_done && !box_empty) state_next = RASTER;
      end
      RASTER: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = x_last & y_last;
        m_axis_tdata  = {15'd0, covered, pix_z};
        if (m_hs && x_last && y_last) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  // Setup capture, beat counting and incremental pixel/row accumulation.
  always_ff @(posedge aclk) begin
    if (areset) begin
      beat_cnt <= 4'd0;
      x_len    <= 16'd0;
      y_count  <= 8'd0;
      l0_base  <= 32'd0;
      l1_base  <= 32'd0;
      dl0x     <= 32'd0;
      dl1x     <= 32'd0;
      dl0y     <= 32'd0;
      dl1y     <= 32'd0;
      z_base   <= 16'd0;
      dzx      <= 16'd0;
      dzy      <= 16'd0;
      row_l0   <= 32'd0;
      row_l1   <= 32'd0;
      pix_l0   <= 32'd0;
      pix_l1   <= 32'd0;
      row_z    <= 16'd0;
      pix_z    <= 16'd0;
      x_cnt    <= 16'd0;
      y_cnt    <= 8'd0;
    end else if (s_hs) begin
      case (beat_cnt)
        4'd0: begin
          y_count <= s_axis_tdata[23:16];
          x_len   <= s_axis_tdata[15:0];
        end
        4'd1: l0_base <= s_axis_tdata;
        4'd2: l1_base <= s_axis_tdata;
        4'd3: dl0x    <= s_axis_tdata;
        4'd4: dl1x    <= s_axis_tdata;
        4'd5: dl0y    <= s_axis_tdata;
        4'd6: dl1y    <= s_axis_tdata;
        4'd7: z_base  <= s_axis_tdata[15:0];
        4'd8: dzx     <= s_axis_tdata[15:0];
        4'd9: dzy     <= s_axis_tdata[15:0];
        default: ;
      endcase
      // Beat 9 ends the packet regardless of tlast; an earlier tlast drops it.
      if (last_beat || s_axis_tlast) beat_cnt <= 4'd0;
      else                           beat_cnt <= beat_cnt + 4'd1;
      if (last_beat) begin
        row_l0 <= l0_base;
        row_l1 <= l1_base;
        row_z  <= z_base;
        pix_l0 <= l0_base;
        pix_l1 <= l1_base;
        pix_z  <= z_base;
        x_cnt  <= 16'd0;
        y_cnt  <= 8'd0;
      end
    end else if (m_hs) begin
      if (x_last) begin
        x_cnt <= 16'd0;
        if (!y_last) begin
          y_cnt  <= y_cnt + 8'd1;
          row_l0 <= row_l0 + dl0y;
          row_l1 <= row_l1 + dl1y;
          row_z  <= row_z + dzy;
          pix_l0 <= row_l0 + dl0y;
          pix_l1 <= row_l1 + dl1y;
          pix_z  <= row_z + dzy;
        end
      end else begin
        x_cnt  <= x_cnt + 16'd1;
        pix_l0 <= pix_l0 + dl0x;
        pix_l1 <= pix_l1 + dl1x;
        pix_z  <= pix_z + dzx;
      end
    end
  end

endmodule

// File: tb/tb_raster_core.sv
// Directed bench for raster_core: setup packets in, pixel words checked
// against hand-computed constants and a closed-form x/y model.
module tb_raster_core;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;

  raster_core dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc++;

  int checks = 0;
  int errors = 0;

  logic [31:0] pa [10];
  logic [31:0] pb [10];
  logic [31:0] pz [10];

  int          done_cyc, first_cyc, px_cnt, tlast_cnt, bubbles, sready_bad, unstable;
  logic [31:0] first_w, second_w, w128, last_w;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat(input int which, input int i);
    if (which == 0)      return pa[i];
    else if (which == 1) return pb[i];
    else                 return pz[i];
  endfunction

  function automatic logic [31:0] exp_word(input int which, input int x, input int y);
    logic [31:0]        xx, yy, l0, l1, b7, b8, b9;
    logic [15:0]        z;
    logic signed [32:0] s;
    logic               cov;
    xx = x;
    yy = y;
    l0 = beat(which, 1) + xx * beat(which, 3) + yy * beat(which, 5);
    l1 = beat(which, 2) + xx * beat(which, 4) + yy * beat(which, 6);
    b7 = beat(which, 7);
    b8 = beat(which, 8);
    b9 = beat(which, 9);
    z  = b7[15:0] + xx[15:0] * b8[15:0] + yy[15:0] * b9[15:0];
    s  = $signed({l0[31], l0}) + $signed({l1[31], l1});
    cov = !l0[31] && !l1[31] && (s <= 33'sh040000000);
    return {15'd0, cov, z};
  endfunction

  // Called at a negedge; returns at the negedge after the final handshake.
  task automatic send_beats(input int which, input int nbeats, input int tlast_at);
    int guard;
    for (int i = 0; i < nbeats; i++) begin
      s_axis_tdata  = beat(which, i);
      s_axis_tlast  = (i == tlast_at);
      s_axis_tvalid = 1'b1;
      guard = 0;
      while (!s_axis_tready && guard < 5000) begin
        @(negedge aclk);
        guard++;
      end
      if (guard >= 5000) begin
        checks++;
        errors++;
        $error("FAIL send_wait: observed tready low for %0d cycles, required below 5000", guard);
      end
      @(negedge aclk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    done_cyc = cyc;
  endtask

  // mode 0: tready held high; mode 1: one cycle low, two high.
  task automatic collect(input int which, input int mode, input int stop_at);
    int          n, xl, cnt, k, guard;
    logic        held;
    logic [31:0] hold_d;
    logic        hold_l;
    n  = (which == 0) ? 2176 : 1270;
    xl = (which == 0) ? 128 : 127;
    cnt = 0; k = 0; guard = 0; held = 1'b0; hold_d = 32'd0; hold_l = 1'b0;
    first_cyc = -1; bubbles = 0; sready_bad = 0; unstable = 0; tlast_cnt = 0;
    while (cnt < stop_at && guard < 20000) begin
      @(negedge aclk);
      guard++;
      m_axis_tready = (mode == 0) ? 1'b1 : (k % 3 != 0);
      k++;
      if (m_axis_tvalid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (s_axis_tready) sready_bad++;
        if (held && (m_axis_tdata !== hold_d || m_axis_tlast !== hold_l)) unstable++;
        if (m_axis_tready) begin
          if (cnt == 0)   first_w  = m_axis_tdata;
          if (cnt == 1)   second_w = m_axis_tdata;
          if (cnt == 128) w128     = m_axis_tdata;
          last_w = m_axis_tdata;
          if (m_axis_tlast) tlast_cnt++;
          chk("pixel", m_axis_tdata, exp_word(which, cnt % xl, cnt / xl));
          chk("pixel_tlast", {31'd0, m_axis_tlast}, {31'd0, cnt == n - 1});
          cnt++;
          held = 1'b0;
        end else begin
          held   = 1'b1;
          hold_d = m_axis_tdata;
          hold_l = m_axis_tlast;
        end
      end else if (first_cyc >= 0) begin
        bubbles++;
      end
    end
    if (guard >= 20000) begin
      checks++;
      errors++;
      $error("FAIL collect_wait: observed %0d pixels, required %0d", cnt, stop_at);
    end
    px_cnt = cnt;
    m_axis_tready = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    @(negedge aclk);
    chk({tag, "_tvalid"}, {31'd0, m_axis_tvalid}, 32'd0);
    chk({tag, "_s_tready"}, {31'd0, s_axis_tready}, 32'd1);
  endtask

  initial begin
    pa = '{32'h00110080, 32'h10000000, 32'h20000000, 32'h00100000, 32'h00200000,
           32'h00150000, 32'h00250000, 32'h00001000, 32'h00000010, 32'h00000020};
    pb = '{32'h000A007F, 32'h08000000, 32'h18000000, 32'h00080000, 32'h00180000,
           32'h00120000, 32'h00220000, 32'h00000800, 32'h00000008, 32'h00000018};
    pz = '{32'h00050000, 32'h10000000, 32'h20000000, 32'h00100000, 32'h00200000,
           32'h00150000, 32'h00250000, 32'h00001000, 32'h00000010, 32'h00000020};

    areset = 1'b1;
    s_axis_tdata = 32'd0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge aclk);
    chk("rst_s_tready", {31'd0, s_axis_tready}, 32'd1);
    chk("rst_tvalid",   {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_tlast",    {31'd0, m_axis_tlast},  32'd0);
    chk("rst_tdata",    m_axis_tdata,           32'd0);
    areset = 1'b0;
    @(negedge aclk);

    // Pkt A, sink always ready.
    fork
      send_beats(0, 10, 9);
      collect(0, 0, 2176);
    join
    chk("a_count",    px_cnt,    32'd2176);
    chk("a_first",    first_w,   32'h00011000);
    chk("a_second",   second_w,  32'h00011010);
    chk("a_x0y1",     w128,      32'h00011020);
    chk("a_last",     last_w,    32'h000019F0);
    chk("a_tlasts",   tlast_cnt, 32'd1);
    chk("a_bubbles",  bubbles,   32'd0);
    chk("a_latency",  first_cyc, done_cyc);
    chk("a_s_tready", sready_bad, 32'd0);
    check_idle("a_end");

    // Pkt B, sink 1 low / 2 high.
    fork
      send_beats(1, 10, 9);
      collect(1, 1, 1270);
    join
    chk("b_count",  px_cnt,    32'd1270);
    chk("b_first",  first_w,   32'h00010800);
    chk("b_last",   last_w,    32'h00010CC8);
    chk("b_tlasts", tlast_cnt, 32'd1);
    chk("b_stable", unstable,  32'd0);
    check_idle("b_end");

    // Pkt B offered during Pkt A raster.
    fork
      begin
        send_beats(0, 10, 9);
        send_beats(1, 10, 9);
      end
      begin
        collect(0, 0, 2176);
        chk("bp_a_count",    px_cnt,     32'd2176);
        chk("bp_a_last",     last_w,     32'h000019F0);
        chk("bp_a_s_tready", sready_bad, 32'd0);
        collect(1, 0, 1270);
        chk("bp_b_count", px_cnt,  32'd1270);
        chk("bp_b_first", first_w, 32'h00010800);
        chk("bp_b_last",  last_w,  32'h00010CC8);
      end
    join
    check_idle("bp_end");

    // Early tlast on beat 4 drops the partial packet.
    fork
      begin
        send_beats(1, 5, 4);
        send_beats(0, 10, -1);
      end
      collect(0, 0, 2176);
    join
    chk("early_count",  px_cnt,    32'd2176);
    chk("early_first",  first_w,   32'h00011000);
    chk("early_last",   last_w,    32'h000019F0);
    chk("early_tlasts", tlast_cnt, 32'd1);
    check_idle("early_end");

    // x_len == 0: nothing emitted, input stays open.
    send_beats(2, 10, 9);
    begin
      int seen_valid, seen_busy;
      seen_valid = 0;
      seen_busy  = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge aclk);
        if (m_axis_tvalid)  seen_valid++;
        if (!s_axis_tready) seen_busy++;
      end
      chk("empty_tvalid", seen_valid, 32'd0);
      chk("empty_busy",   seen_busy,  32'd0);
    end

    // Reset mid-raster, then a fresh Pkt A.
    fork
      send_beats(0, 10, 9);
      collect(0, 0, 100);
    join
    chk("mid_count", px_cnt, 32'd100);
    areset = 1'b1;
    @(negedge aclk);
    chk("mid_rst_tvalid",   {31'd0, m_axis_tvalid}, 32'd0);
    chk("mid_rst_s_tready", {31'd0, s_axis_tready}, 32'd1);
    chk("mid_rst_tdata",    m_axis_tdata,           32'd0);
    areset = 1'b0;
    @(negedge aclk);
    fork
      send_beats(0, 10, 9);
      collect(0, 0, 2176);
    join
    chk("post_count",  px_cnt,    32'd2176);
    chk("post_first",  first_w,   32'h00011000);
    chk("post_x0y1",   w128,      32'h00011020);
    chk("post_last",   last_w,    32'h000019F0);
    chk("post_tlasts", tlast_cnt, 32'd1);
    check_idle("post_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
